// File: rtl/pe_dc_seq.sv
// rtl/pe_dc_seq.sv - sequential XNOR-popcount decoder PE with optional unpooling (PE_DC_SEQ_UNPOOL_EN)
module pe_dc_seq #(
  parameter  int D            = 4,
  parameter  int FH           = 3,
  parameter  int FW           = 3,
  parameter  int CHUNK        = 12,
  parameter  int NF           = 2,
  parameter  int POOL_H       = 2,
  parameter  int POOL_W       = 2,
  parameter  int REF_WIDTH    = 6,
  parameter  int PINDEX_WIDTH = 3,
  localparam int N            = FH * FW * D,
  localparam int NCH          = N / CHUNK,
  localparam int P            = POOL_H * POOL_W,
`ifdef PE_DC_SEQ_UNPOOL_EN
  localparam int OUT_WIDTH    = NF * P,
`else
  localparam int OUT_WIDTH    = NF,
`endif
  localparam int FIDX_W       = (NF > 1) ? $clog2(NF) : 1,
  localparam int CIDX_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 data_in,
  input  logic [PINDEX_WIDTH-1:0]      pindex,
  input  logic [NF*REF_WIDTH-1:0]      norm_ref,
  output logic [FIDX_W-1:0]            w_fidx,
  output logic [CIDX_W-1:0]            w_cidx,
  input  logic [CHUNK-1:0]             weight_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         data_out
);

  localparam int ACC_WIDTH = $clog2(N + 1);
  localparam int CMP_W     = (ACC_WIDTH > REF_WIDTH) ? ACC_WIDTH : REF_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0]            data_q;
  logic [PINDEX_WIDTH-1:0] pidx_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [FIDX_W-1:0]       f_q;
  logic [CIDX_W-1:0]       c_q;
  logic [NF-1:0]           res_q;

  logic [CHUNK-1:0]        match;
  logic [ACC_WIDTH-1:0]    pc;
  logic [ACC_WIDTH-1:0]    sum;
  logic [REF_WIDTH-1:0]    ref_f;
  logic                    hit;
  logic                    last_c;
  logic                    last_f;
  logic [OUT_WIDTH-1:0]    unpooled;

  assign last_c = (c_q == CIDX_W'(NCH - 1));
  assign last_f = (f_q == FIDX_W'(NF - 1));

  // Score the current chunk of the current filter against its threshold
  always_comb begin
    match = ~(data_q[int'(c_q)*CHUNK +: CHUNK] ^ weight_in);
    pc    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pc = pc + ACC_WIDTH'(match[i]);
    end
    sum   = acc_q + pc;
    ref_f = norm_ref[int'(f_q)*REF_WIDTH +: REF_WIDTH];
    hit   = (CMP_W'(sum) >= CMP_W'(ref_f));
  end

`ifdef PE_DC_SEQ_UNPOOL_EN
  // Scatter each filter result into its unpooling cell; out-of-range index yields zeros
  always_comb begin
    unpooled = '0;
    for (int f = 0; f < NF; f++) begin
      for (int p = 0; p < P; p++) begin
        if (pidx_q == PINDEX_WIDTH'(p)) begin
          unpooled[f*P + p] = res_q[f];
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{pidx_q, 32'(P)};

  // Without unpooling the filter results are the output directly
  always_comb begin
    unpooled = res_q;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake/ROM-address outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_fidx    = '0;
    w_cidx    = '0;
    data_out  = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_fidx = f_q;
        w_cidx = c_q;
        if (last_c && last_f) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        data_out  = unpooled;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window capture, chunk accumulation and per-filter thresholding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      pidx_q <= '0;
      acc_q  <= '0;
      f_q    <= '0;
      c_q    <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= data_in;
            pidx_q <= pindex;
            acc_q  <= '0;
            f_q    <= '0;
            c_q    <= '0;
          end
        end
        S_COMPUTE: begin
          if (last_c) begin
            res_q[f_q] <= hit;
            acc_q      <= '0;
            c_q        <= '0;
            if (!last_f) f_q <= f_q + FIDX_W'(1);
          end else begin
            acc_q <= sum;
            c_q   <= c_q + CIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dc_seq.sv
// tb/tb_pe_dc_seq.sv - table-driven scoreboard bench for pe_dc_seq
module tb_pe_dc_seq;

  localparam int N     = 36;
  localparam int CHUNK = 12;
  localparam int NF    = 2;
`ifdef PE_DC_SEQ_UNPOOL_EN
  localparam int OUT_WIDTH = 8;
`else
  localparam int OUT_WIDTH = 2;
`endif

  typedef struct {
    logic [N-1:0] data;
    logic [N-1:0] w0;
    logic [N-1:0] w1;
    logic [5:0]   r0;
    logic [5:0]   r1;
    logic [2:0]   pidx;
    logic [1:0]   res;   // {f1, f0} expected threshold results
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         data_in;
  logic [2:0]           pindex;
  logic [11:0]          norm_ref;
  logic [0:0]           w_fidx;
  logic [1:0]           w_cidx;
  logic [CHUNK-1:0]     weight_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] data_out;

  logic [N-1:0]         wrom [NF];
  logic [OUT_WIDTH-1:0] sb_q [$];
  vec_t                 tbl [7];
  int                   n_vec  = 0;
  int                   n_miss = 0;

  always #5 clk = ~clk;

  always_comb weight_in = wrom[w_fidx][int'(w_cidx)*CHUNK +: CHUNK];

  pe_dc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .pindex    (pindex),
    .norm_ref  (norm_ref),
    .w_fidx    (w_fidx),
    .w_cidx    (w_cidx),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] exp_out(input logic [1:0] r, input logic [2:0] pidx);
    logic [OUT_WIDTH-1:0] e;
    e = '0;
`ifdef PE_DC_SEQ_UNPOOL_EN
    if (pidx < 3'd4) begin
      e[int'(pidx)]     = r[0];
      e[4 + int'(pidx)] = r[1];
    end
`else
    e = r;
`endif
    return e;
  endfunction

  task automatic load(input vec_t v);
    data_in  = v.data;
    pindex   = v.pidx;
    norm_ref = {v.r1, v.r0};
    wrom[0]  = v.w0;
    wrom[1]  = v.w1;
  endtask

  task automatic run_vec(input vec_t v, input string name, input int hold, input bit seq_chk);
    int                   k;
    logic [11:0]          cs;
    logic [5:0]           fs;
    logic [OUT_WIDTH-1:0] held;
    logic [OUT_WIDTH-1:0] e;
    @(negedge clk);
    load(v);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_accept"}, 64'(in_ready), 64'd1);
    sb_q.push_back(exp_out(v.res, v.pidx));
    @(negedge clk);
    in_valid = 1'b0;
    cs = '0;
    fs = '0;
    k  = 0;
    while (!out_valid && k < 100) begin
      if (k < 6) begin
        cs[k*2 +: 2] = w_cidx;
        fs[k]        = w_fidx;
      end
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'd6);
    if (seq_chk) begin
      check({name, "_cidx_seq"}, 64'(cs), 64'b10_01_00_10_01_00);
      check({name, "_fidx_seq"}, 64'(fs), 64'b111000);
    end
    held = data_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      data_in  = ~data_in;
      pindex   = pindex + 3'd1;
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check({name, "_hold_stable"}, 64'(data_out), 64'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_data_out"}, 64'(data_out), 64'(e));
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
    check({name, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  // Drive reset, the vector table and the multi-cycle corner cases
  initial begin
    bit seen;
    //               data            w0              w1              r0  r1  pidx res
    tbl[0] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 6'd36, 6'd36, 3'd2, 2'b11};
    tbl[1] = '{36'hFFFFFFFFF, 36'h000000000, 36'h000000000, 6'd1,  6'd0,  3'd0, 2'b10};
    tbl[2] = '{36'hFFFFFFFFF, 36'hAAAAAAAAA, 36'hAAAAAAAAA, 6'd18, 6'd19, 3'd3, 2'b01};
    tbl[3] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 6'd36, 6'd36, 3'd5, 2'b11};
    tbl[4] = '{36'h000000FFF, 36'h000000000, 36'hFFFFFF000, 6'd25, 6'd0,  3'd1, 2'b10};
    tbl[5] = '{36'h000000FFF, 36'h000000000, 36'hFFFFFFFFF, 6'd24, 6'd12, 3'd3, 2'b11};
    tbl[6] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 6'd37, 6'd63, 3'd0, 2'b00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    pindex    = '0;
    norm_ref  = '0;
    wrom[0]   = '0;
    wrom[1]   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_w_fidx", 64'(w_fidx), 64'd0);
    check("rst_w_cidx", 64'(w_cidx), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i), 0, i == 0);
    end

    run_vec(tbl[2], "hold", 5, 1'b0);
    run_vec(tbl[1], "after_hold", 0, 1'b0);

    @(negedge clk);
    load(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_cidx", 64'(w_cidx), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data_out", 64'(data_out), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    run_vec(tbl[0], "post_rst", 0, 1'b1);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pe_dc_seq.md
# pe_dc_seq

Sequential, parametrised decoder processing element for the binarised encoder-decoder network. For each accepted input window it performs a chunked, multi-cycle XNOR-popcount against NF filters and thresholds each filter's score with its own normalisation reference. It then scatters each binary result into a POOL_H×POOL_W unpooling cell selected by the pooling index. It sits between the window buffer (upstream valid/ready) and the decoder output packer (downstream valid/ready), and its weights come from an external combinational ROM addressed by the block.

## Interface
- D, 4: input channel depth.
- FH, 3: filter height.
- FW, 3: filter width.
- CHUNK, 12: window bits processed per cycle; must divide N = FH·FW·D.
- NF, 2: output filters (channels) per window.
- POOL_H, 2: unpooling height.
- POOL_W, 2: unpooling width.
- REF_WIDTH, 6: width of each normalisation reference.
- PINDEX_WIDTH, 3: pooling-index width; P = POOL_H·POOL_W.
- Derived: NCH = N/CHUNK; ACC_WIDTH = clog2(N+1); OUT_WIDTH = NF·P (see Configuration).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  window present.
- in_ready  out  1  block accepts a window.
- data_in  in  N  binary window, bit 0 = chunk 0 LSB.
- pindex  in  PINDEX_WIDTH  unpooling position in 0..P-1.
- norm_ref  in  NF·REF_WIDTH  static thresholds; filter f at [f·REF_WIDTH +: REF_WIDTH].
- w_fidx  out  clog2(NF)  filter index for the weight ROM.
- w_cidx  out  clog2(NCH)  chunk index for the weight ROM.
- weight_in  in  CHUNK  weights for (w_fidx, w_cidx), combinational same cycle.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- data_out  out  OUT_WIDTH  unpooled result.

## Operation
- States: IDLE, COMPUTE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, register data_in and pindex, clear the accumulator, set f=0, c=0, and go to COMPUTE.
- COMPUTE:
  - in_ready=0. Drive w_fidx=f and w_cidx=c.
  - pc = popcount(~(data_chunk[c] ^ weight_in)).
  - When c<NCH-1: acc += pc and c++.
  - When c=NCH-1: res[f] = ((acc+pc) ≥ zero-extended norm_ref[f]) (unsigned), acc=0, c=0.
    - If f<NF-1: f++.
    - If f=NF-1: go to OUT.
- OUT:
  - out_valid=1 and data_out are held stable until out_ready=1. Then go to IDLE.
  - No new window is accepted in the handshake cycle.
- Unpooling: data_out[f·P + pindex] = res[f]; all other bits are 0.
- If the registered pindex ≥ P, data_out is all zeros.
- The accumulator never overflows: ACC_WIDTH covers N.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - data_out=0, w_fidx=0, w_cidx=0, acc=0.
- Reset mid-COMPUTE or mid-OUT discards the window. No out_valid is produced for it.
- in_valid while not IDLE is ignored (no capture).
- norm_ref must be static for the duration of a window.

## Timing
- Window accepted at rising edge E. Filter f, chunk k is computed in cycle E+1+f·NCH+k.
- out_valid rises after edge E+NF·NCH. Latency is NF·NCH cycles; for the defaults, 6 cycles.
- in_ready returns high one cycle after the out handshake edge.
- Peak throughput is one window per NF·NCH+2 cycles.
- weight_in must settle within the cycle that w_fidx/w_cidx are driven. The ROM has no extra latency.

## Configuration
- PE_DC_SEQ_UNPOOL_EN defined:
  - OUT_WIDTH = NF·P, with unpooling as described above.
  - The pindex ≥ P rule applies.
- PE_DC_SEQ_UNPOOL_EN undefined:
  - OUT_WIDTH = NF, and data_out[f] = res[f].
  - pindex is captured but unused.
  - POOL_H/POOL_W are ignored.
  - Latency is unchanged.

## Test plan
All scenarios use the defaults: N=36, NCH=3, NF=2, P=4, with the macro defined.
1. data_in all 1, weight_in all 1, norm_ref 36/36, pindex=2 → data_out=8'b0100_0100. out_valid is seen 6 cycles after acceptance, and w_cidx sequence is 0,1,2,0,1,2.
2. data_in all 1, weight_in all 0, norm_ref f0=1, f1=0, pindex=0 → acc=0, data_out=8'b0001_0000 (f0=0, f1=1, boundary ≥).
3. Weights alternate 1010…, data_in all 1 (18 matches), norm_ref f0=18, f1=19, pindex=3 → data_out=8'b0000_1000.
4. Hold out_ready=0 for 5 cycles after out_valid → data_out stable, in_ready=0, in_valid ignored. Then out_ready=1 → in_ready=1 on the next cycle, and the next window is accepted normally.
5. Assert rst_n=0 for one cycle during COMPUTE cycle 3 → afterwards out_valid=0, data_out=0, in_ready=1. A fresh window then reproduces scenario 1's result exactly.
6. pindex=5 with scenario 1 data → data_out=8'b0000_0000. Rebuilt without PE_DC_SEQ_UNPOOL_EN → data_out=2'b11.
